// File: rtl/xrv_issue_ctrl_pkg.sv
// Shared types and constants for the fetch-to-decode issue controller.
// The issue-state enum, the RV opcode constants and the buffer payload struct live here.
package xrv_issue_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REDIR = 2'd1,
    RUN   = 2'd2
  } issue_state_t;

  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_AUIPC = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b11011;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            is_compressed;
  } ib_entry_t;

  // Load-use check. U-type and JAL encodings have no source registers.
  function automatic logic load_use(input logic [XLEN-1:0] i, input logic [4:0] rd);
    logic uses_rs;
    uses_rs = !(i[6:2] == OP_LUI || i[6:2] == OP_AUIPC || i[6:2] == OP_JAL);
    return uses_rs && (rd != 5'd0) && (rd == i[19:15] || rd == i[24:20]);
  endfunction

endpackage

// File: rtl/xrv_ib_fifo.sv
// Shift-style instruction buffer. Entry 0 is the head, which is a plain register.
// Push and pop can happen in the same cycle, including when the buffer is full; clear wins.
module xrv_ib_fifo
  import xrv_issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      rstb,
  input  logic      push,
  input  ib_entry_t push_data,
  input  logic      pop,
  input  logic      clear,
  output logic      full,
  output logic      empty,
  output ib_entry_t head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  ib_entry_t       ent [DEPTH];
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   wr_idx;

  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);
  assign head   = ent[0];
  // After a pop, every entry moves down one slot, so the write slot moves down with it.
  assign wr_idx = pop ? (cnt - CW'(1)) : cnt;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      cnt <= '0;
      for (int i = 0; i < int'(DEPTH); i++) ent[i] <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) ent[i] <= ent[i+1];
      end
      if (push) ent[wr_idx[AW-1:0]] <= push_data;
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/xrv_issue_ctrl.sv
// Issue controller: buffers fetched instructions, issues one per cycle to decode,
// stalls on load-use and ex back-pressure, and handles redirects with a 1-bit fetch epoch.
module xrv_issue_ctrl
  import xrv_issue_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IB_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        f_valid,
  output logic        f_ready,
  input  logic [31:0] f_inst,
  input  logic [31:0] f_pc,
  input  logic        f_is_compressed,
  input  logic        f_epoch,
  output logic        redirect_req,
  output logic [31:0] redirect_addr,
  output logic        epoch,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_is_compressed,
  output logic        inst_valid,
  output logic        flush,
  input  logic        id_jmp,
  input  logic [31:0] id_jmp_addr,
  input  logic        ex_flush,
  input  logic [31:0] ex_flush_addr,
  input  logic        ex_stall,
  input  logic        ex_valid,
  input  logic        ex_op_load,
  input  logic [4:0]  ex_dest
);

  issue_state_t state;
  ib_entry_t    head;
  ib_entry_t    push_data;
  logic         full;
  logic         empty;
  logic         hazard;
  logic         jmp_take;
  logic         redirect_now;
  logic         push;

  assign hazard = ex_valid && ex_op_load && load_use(head.inst, ex_dest);

  // Issue depends only on registered state and ex-side inputs, never on id_jmp.
  assign inst_valid = !empty && (state == RUN) && !ex_stall && !ex_flush && !hazard;

  // A JAL only redirects once it actually leaves the buffer.
  assign jmp_take     = id_jmp && inst_valid;
  assign redirect_now = (state == BOOT) || ex_flush || jmp_take;

  // Data arriving alongside a redirect belongs to the old epoch and is dropped.
  assign f_ready   = !full;
  assign push      = f_valid && f_ready && (f_epoch == epoch) && !redirect_now;
  assign push_data = '{inst: f_inst, pc: f_pc, is_compressed: f_is_compressed};

  assign inst               = head.inst;
  assign inst_pc            = head.pc;
  assign inst_is_compressed = head.is_compressed;
  assign flush              = ex_flush;

  xrv_ib_fifo #(
    .DEPTH (IB_DEPTH)
  ) u_ib (
    .clk       (clk),
    .rstb      (rstb),
    .push      (push),
    .push_data (push_data),
    .pop       (inst_valid),
    .clear     (redirect_now),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  // Redirect sequencing; ex_flush outranks a decode-stage JAL.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state         <= BOOT;
      epoch         <= 1'b0;
      redirect_req  <= 1'b0;
      redirect_addr <= '0;
    end else begin
      redirect_req <= 1'b0;
      if (state == BOOT) begin
        state         <= REDIR;
        epoch         <= ~epoch;
        redirect_req  <= 1'b1;
        redirect_addr <= RESET_PC;
      end else if (ex_flush) begin
        state         <= REDIR;
        epoch         <= ~epoch;
        redirect_req  <= 1'b1;
        redirect_addr <= ex_flush_addr;
      end else if (jmp_take) begin
        state         <= REDIR;
        epoch         <= ~epoch;
        redirect_req  <= 1'b1;
        redirect_addr <= id_jmp_addr;
      end else if (state == REDIR && push) begin
        state <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_xrv_issue_ctrl.sv
// Directed bench for xrv_issue_ctrl: boot redirect, streaming, load-use stall,
// JAL and ex_flush redirects, back-pressure and mid-run reset.
module tb_xrv_issue_ctrl;

  localparam logic [31:0] ALU = 32'h0062_81B3; // add x3,x5,x6
  localparam logic [31:0] NOP = 32'h0000_0013; // addi x0,x0,0
  localparam logic [31:0] JAL = 32'h0052_80EF; // jal x1 with rs fields == 5 in the immediate

  logic        clk = 1'b0;
  logic        rstb;
  logic        f_valid;
  logic        f_ready;
  logic [31:0] f_inst;
  logic [31:0] f_pc;
  logic        f_is_compressed;
  logic        f_epoch;
  logic        redirect_req;
  logic [31:0] redirect_addr;
  logic        epoch;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_is_compressed;
  logic        inst_valid;
  logic        flush;
  logic        id_jmp;
  logic [31:0] id_jmp_addr;
  logic        ex_flush;
  logic [31:0] ex_flush_addr;
  logic        ex_stall;
  logic        ex_valid;
  logic        ex_op_load;
  logic [4:0]  ex_dest;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  xrv_issue_ctrl #(
    .RESET_PC (32'h0000_0000),
    .IB_DEPTH (2)
  ) dut (
    .clk                (clk),
    .rstb               (rstb),
    .f_valid            (f_valid),
    .f_ready            (f_ready),
    .f_inst             (f_inst),
    .f_pc               (f_pc),
    .f_is_compressed    (f_is_compressed),
    .f_epoch            (f_epoch),
    .redirect_req       (redirect_req),
    .redirect_addr      (redirect_addr),
    .epoch              (epoch),
    .inst               (inst),
    .inst_pc            (inst_pc),
    .inst_is_compressed (inst_is_compressed),
    .inst_valid         (inst_valid),
    .flush              (flush),
    .id_jmp             (id_jmp),
    .id_jmp_addr        (id_jmp_addr),
    .ex_flush           (ex_flush),
    .ex_flush_addr      (ex_flush_addr),
    .ex_stall           (ex_stall),
    .ex_valid           (ex_valid),
    .ex_op_load         (ex_op_load),
    .ex_dest            (ex_dest)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1 ns after the edge, checks happen 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ep, input logic c);
    f_valid = v; f_pc = pc; f_inst = ins; f_epoch = ep; f_is_compressed = c;
  endtask

  task automatic exq(input logic v, input logic ld, input logic [4:0] rd, input logic st);
    ex_valid = v; ex_op_load = ld; ex_dest = rd; ex_stall = st;
  endtask

  initial begin
    rstb = 1'b0;
    fetch(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    exq(1'b0, 1'b0, 5'd0, 1'b0);
    id_jmp = 1'b0; id_jmp_addr = 32'h0; ex_flush = 1'b0; ex_flush_addr = 32'h0;
    step(); step(); #1;
    chk("rst_redirect_req", 32'(redirect_req), 32'd0);
    chk("rst_redirect_addr", redirect_addr, 32'h0);
    chk("rst_epoch", 32'(epoch), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_f_ready", 32'(f_ready), 32'd1);

    // BOOT cycle
    rstb = 1'b1; #1;
    chk("boot_inst_valid", 32'(inst_valid), 32'd0);
    chk("boot_redirect_req", 32'(redirect_req), 32'd0);
    step();

    // REDIR: boot redirect visible, first matching-epoch fetch accepted
    fetch(1'b1, 32'h0, ALU, 1'b1, 1'b0); #1;
    chk("boot_redir_req", 32'(redirect_req), 32'd1);
    chk("boot_redir_addr", redirect_addr, 32'h0);
    chk("boot_epoch", 32'(epoch), 32'd1);
    chk("redir_inst_valid", 32'(inst_valid), 32'd0);
    chk("redir_f_ready", 32'(f_ready), 32'd1);
    step();

    // Back-to-back stream
    for (int k = 0; k < 4; k++) begin
      if (k == 3) fetch(1'b1, 32'h10, JAL, 1'b1, 1'b0);
      else        fetch(1'b1, 32'(4 * (k + 1)), ALU, 1'b1, 1'b0);
      #1;
      chk($sformatf("stream%0d_valid", k), 32'(inst_valid), 32'd1);
      chk($sformatf("stream%0d_pc", k), inst_pc, 32'(4 * k));
      chk($sformatf("stream%0d_f_ready", k), 32'(f_ready), 32'd1);
      if (k == 0) chk("stream_single_req", 32'(redirect_req), 32'd0);
      step();
    end

    // JAL held one cycle so 0x14 is buffered behind it
    fetch(1'b1, 32'h14, ALU, 1'b1, 1'b0);
    exq(1'b0, 1'b0, 5'd0, 1'b1); #1;
    chk("jal_stall_valid", 32'(inst_valid), 32'd0);
    step();
    fetch(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    exq(1'b1, 1'b1, 5'd5, 1'b0);
    id_jmp = 1'b1; id_jmp_addr = 32'h100; #1;
    chk("jal_issue_valid", 32'(inst_valid), 32'd1);
    chk("jal_issue_pc", inst_pc, 32'h10);
    chk("jal_full_f_ready", 32'(f_ready), 32'd0);
    chk("jal_no_flush", 32'(flush), 32'd0);
    step();
    id_jmp = 1'b0;
    exq(1'b0, 1'b0, 5'd0, 1'b0);
    fetch(1'b1, 32'h18, ALU, 1'b1, 1'b0); #1;
    chk("jal_redir_req", 32'(redirect_req), 32'd1);
    chk("jal_redir_addr", redirect_addr, 32'h100);
    chk("jal_epoch", 32'(epoch), 32'd0);
    chk("jal_drop_14", 32'(inst_valid), 32'd0);
    chk("jal_stale_f_ready", 32'(f_ready), 32'd1);
    step();
    fetch(1'b1, 32'h100, ALU, 1'b0, 1'b0); #1;
    chk("jal_req_pulse", 32'(redirect_req), 32'd0);
    chk("jal_stale_dropped", 32'(inst_valid), 32'd0);
    step();

    // Load-use hazard on add x3,x5,x6 with ex rd=x5
    fetch(1'b1, 32'h104, ALU, 1'b0, 1'b0);
    exq(1'b1, 1'b1, 5'd5, 1'b0); #1;
    chk("hazard_hold", 32'(inst_valid), 32'd0);
    chk("hazard_head_pc", inst_pc, 32'h100);
    step();
    fetch(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    exq(1'b0, 1'b0, 5'd0, 1'b0); #1;
    chk("hazard_release_valid", 32'(inst_valid), 32'd1);
    chk("hazard_release_pc", inst_pc, 32'h100);
    step();
    exq(1'b1, 1'b1, 5'd0, 1'b0); #1;
    chk("x0_no_hazard_valid", 32'(inst_valid), 32'd1);
    chk("x0_no_hazard_pc", inst_pc, 32'h104);
    step();

    // Fill the buffer under ex_stall
    exq(1'b0, 1'b0, 5'd0, 1'b0);
    fetch(1'b1, 32'h108, ALU, 1'b0, 1'b0); #1;
    chk("empty_valid", 32'(inst_valid), 32'd0);
    step();
    fetch(1'b1, 32'h10C, NOP, 1'b0, 1'b1);
    ex_stall = 1'b1; #1;
    chk("stall_fill_valid", 32'(inst_valid), 32'd0);
    step();
    fetch(1'b1, 32'h110, ALU, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d_f_ready", k), 32'(f_ready), 32'd0);
      chk($sformatf("stall%0d_valid", k), 32'(inst_valid), 32'd0);
      chk($sformatf("stall%0d_pc", k), inst_pc, 32'h108);
      chk($sformatf("stall%0d_inst", k), inst, ALU);
      step();
    end
    ex_stall = 1'b0; #1;
    chk("resume0_valid", 32'(inst_valid), 32'd1);
    chk("resume0_pc", inst_pc, 32'h108);
    chk("resume0_f_ready", 32'(f_ready), 32'd0);
    step();
    #1;
    chk("resume1_valid", 32'(inst_valid), 32'd1);
    chk("resume1_pc", inst_pc, 32'h10C);
    chk("resume1_inst", inst, NOP);
    chk("resume1_compressed", 32'(inst_is_compressed), 32'd1);
    chk("resume1_f_ready", 32'(f_ready), 32'd1);
    step();

    // ex_flush beats a simultaneous id_jmp; same-cycle fetch is dropped
    fetch(1'b1, 32'h114, ALU, 1'b0, 1'b0);
    ex_flush = 1'b1; ex_flush_addr = 32'h200;
    id_jmp = 1'b1; id_jmp_addr = 32'h100; #1;
    chk("flush_out", 32'(flush), 32'd1);
    chk("flush_valid", 32'(inst_valid), 32'd0);
    chk("flush_head_pc", inst_pc, 32'h110);
    step();
    ex_flush = 1'b0; id_jmp = 1'b0;
    fetch(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); #1;
    chk("flush_redir_req", 32'(redirect_req), 32'd1);
    chk("flush_redir_addr", redirect_addr, 32'h200);
    chk("flush_epoch", 32'(epoch), 32'd1);
    chk("flush_valid_after", 32'(inst_valid), 32'd0);
    step();
    #1;
    chk("flush_req_pulse", 32'(redirect_req), 32'd0);
    chk("flush_addr_held", redirect_addr, 32'h200);
    chk("flush_drop_114", 32'(inst_valid), 32'd0);

    // Redirect again while still in REDIR
    ex_flush = 1'b1; ex_flush_addr = 32'h300; #1;
    chk("reflush_out", 32'(flush), 32'd1);
    step();
    ex_flush = 1'b0;
    fetch(1'b1, 32'h300, ALU, 1'b0, 1'b0); #1;
    chk("reflush_req", 32'(redirect_req), 32'd1);
    chk("reflush_addr", redirect_addr, 32'h300);
    chk("reflush_epoch", 32'(epoch), 32'd0);
    step();
    fetch(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); #1;
    chk("reflush_issue_valid", 32'(inst_valid), 32'd1);
    chk("reflush_issue_pc", inst_pc, 32'h300);

    // Reset mid-operation
    rstb = 1'b0;
    step();
    #1;
    chk("midrst_redirect_req", 32'(redirect_req), 32'd0);
    chk("midrst_redirect_addr", redirect_addr, 32'h0);
    chk("midrst_epoch", 32'(epoch), 32'd0);
    chk("midrst_inst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_f_ready", 32'(f_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
